inst_fetch: RTL and testbench
=============================

# inst_fetch

Upstream stage of the nexys3 calculator core: it turns a raw `btnS` press into exactly one instruction issue. It debounces the button on a slow sampling tick, captures the 8-bit switch word on the debounced rising edge, and presents it to the decode/execute stage over a valid/ready handshake. It also reports any presses dropped while an instruction is still pending.

## Interface
- `TICK_DIV`, default 50000: clk cycles per debounce sample tick (0.5 ms at 100 MHz); legal range 2..2^20.
- `DEB_SAMPLES`, default 3: consecutive equal samples required to change the debounced level; legal range 2..8.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  8  raw switch word (instruction encoding).
- `btnS`  in  1  raw step button, asynchronous, bouncy.
- `inst_rdy`  in  1  downstream can accept an instruction this cycle.
- `inst_vld`  out  1  `inst_wd` holds a valid instruction.
- `inst_wd`  out  8  captured instruction word.
- `btn_db`  out  1  debounced button level.
- `drop_flag`  out  1  sticky: a press arrived while an instruction was pending.

## Operation
- **Tick generator.** The counter runs 0..TICK_DIV-1. `tick` pulses for one cycle when the count equals TICK_DIV-1, and the counter then wraps to 0.
- **Debounce.**
  - On each `tick`, the synchronised `btnS` shifts into a DEB_SAMPLES-bit history register.
  - If all history bits are 1, `btn_db` becomes 1. If all are 0, it becomes 0. Otherwise `btn_db` holds.
- **Edge detect.** `press` = `btn_db` rising, i.e. current 1 and previous-cycle 0. It is a single-cycle pulse. Release edges do nothing.
- **Issue FSM**, two states:
  - IDLE: on `press`, capture `inst_wd <= sw` (the synchronised `sw` of that cycle) and go to PEND.
  - PEND: `inst_vld` = 1. On `inst_vld && inst_rdy`, go to IDLE.
  - A `press` in PEND does not overwrite `inst_wd`; it sets `drop_flag`.
  - A `press` in the same cycle as acceptance is also dropped: the FSM returns to IDLE and sets `drop_flag`.
- `inst_wd` holds its last value after acceptance and changes only on a new capture.
- `drop_flag` clears only on `rst`.

## Timing
- Reset values:
  - `inst_vld` = 0, `inst_wd` = 8'h00, `btn_db` = 0, `drop_flag` = 0.
  - Tick counter 0, history all 0, FSM IDLE.
- Reset mid-PEND abandons the instruction; `inst_vld` is 0 in the cycle after `rst` is sampled high.
- Input sync latency: 2 cycles (with SYNC_EN).
- Press latency:
  - `btn_db` rises on the DEB_SAMPLES-th tick after `btnS` becomes stable high, counting ticks where the synchronised value is 1.
  - `inst_vld` rises 1 cycle after `btn_db` rises.
- Handshake:
  - `inst_vld` never drops without `inst_rdy`.
  - `inst_wd` is stable while `inst_vld` = 1.
  - With `inst_rdy` held high, `inst_vld` is a 1-cycle pulse.
- Bounce: a glitch shorter than DEB_SAMPLES ticks never toggles `btn_db`.

## Configuration
- `INST_FETCH_SYNC_EN` defined: `btnS` and all `sw` bits pass through a 2-flop synchroniser before use.
- `INST_FETCH_SYNC_EN` undefined: a single register stage is used, and input sync latency is 1 cycle.
- All other behaviour is identical in both builds.

## Structure
- Shared package `calc_pkg`:
  - Opcode constants `OP_PUSH` = 2'b00, `OP_ADD` = 2'b01, `OP_MULT` = 2'b10, `OP_SEND` = 2'b11.
  - Field positions: opcode [7:6], ra [5:4], rb [3:2], rc [1:0], immd [3:0].
  - Instruction width constant `INST_W` = 8.
- Sub-module `btn_debounce` contains the tick generator, history register and `btn_db` level. `inst_fetch` instantiates it and keeps the edge detect and issue FSM.

## Test plan
Bench uses TICK_DIV=4, DEB_SAMPLES=3.
- **Reset:** `rst` high for 3 cycles with `btnS`=1 → all outputs 0 throughout reset; `btn_db` rises at the 3rd tick after release, counting ticks where the synchronised value is 1.
- **Clean press:** `sw`=8'h34, `btnS` high 40 cycles, `inst_rdy`=1 → exactly one `inst_vld` pulse with `inst_wd`=8'h34; no pulse on release.
- **Bounce:** `btnS` toggling every 3 cycles for 30 cycles, then stable high → exactly one `inst_vld`, occurring only after the stable period.
- **Backpressure:** `sw`=8'h9B, press, `inst_rdy`=0 for 20 cycles → `inst_vld` held and `inst_wd`=8'h9B stable. A second press with `sw`=8'h01 during the hold → `drop_flag`=1 and `inst_wd` still 8'h9B. Raising `inst_rdy` → `inst_vld` falls next cycle.
- **Reset mid-PEND:** `rst` asserted while `inst_vld`=1 → `inst_vld`=0 and `inst_wd`=8'h00 next cycle.
- **Sequence:** PUSH(0,4), PUSH(1,3), MULT(0,1,2), SEND(2), i.e. 8'h04, 8'h13, 8'h86, 8'hE0, with `inst_rdy`=1 → four pulses in order with matching `inst_wd` and `drop_flag`=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the nexys3 calculator core: instruction width, opcodes, field positions.
package calc_pkg;

  localparam int INST_W = 8;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 6;
  localparam int RA_MSB   = 5;
  localparam int RA_LSB   = 4;
  localparam int RB_MSB   = 3;
  localparam int RB_LSB   = 2;
  localparam int RC_MSB   = 1;
  localparam int RC_LSB   = 0;
  localparam int IMMD_MSB = 3;
  localparam int IMMD_LSB = 0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_PEND = 1'b1
  } fetch_state_t;

  function automatic logic [1:0] inst_opcode(input logic [INST_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction issue handshake between fetch (master) and decode/execute (slave).
interface inst_fetch_if;
  import calc_pkg::*;

  logic              inst_vld;
  logic              inst_rdy;
  logic [INST_W-1:0] inst_wd;

  modport master (output inst_vld, output inst_wd, input inst_rdy);
  modport slave  (input inst_vld, input inst_wd, output inst_rdy);

endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: sample tick generator, DEB_SAMPLES-deep history, debounced level.
// Expects an already-synchronised input; level changes on the tick that completes the run.
module btn_debounce #(
  parameter int TICK_DIV    = 50000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  output logic btn_db
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]          cnt;
  logic                   tick;
  logic [DEB_SAMPLES-1:0] hist;
  logic [DEB_SAMPLES-1:0] hist_nxt;

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign hist_nxt = {hist[DEB_SAMPLES-2:0], btn_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hist   <= '0;
      btn_db <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        hist <= hist_nxt;
        // A mixed history keeps the previous level.
        if (&hist_nxt)
          btn_db <= 1'b1;
        else if (~|hist_nxt)
          btn_db <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Turns one debounced btnS press into one instruction issue of the switch word over valid/ready.
// INST_FETCH_SYNC_EN selects a 2-flop input synchroniser; otherwise a single register stage.
module inst_fetch import calc_pkg::*; #(
  parameter int TICK_DIV    = 50000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] sw,
  input  logic              btnS,
  inst_fetch_if.master      inst,
  output logic              btn_db,
  output logic              drop_flag
);

  logic              btn_s;
  logic [INST_W-1:0] sw_s;

`ifdef INST_FETCH_SYNC_EN
  logic [INST_W:0] sync_q1;
  logic [INST_W:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {btnS, sw};
      sync_q2 <= sync_q1;
    end
  end

  assign {btn_s, sw_s} = sync_q2;
`else
  logic [INST_W:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= '0;
    else
      sync_q <= {btnS, sw};
  end

  assign {btn_s, sw_s} = sync_q;
`endif

  btn_debounce #(
    .TICK_DIV    (TICK_DIV),
    .DEB_SAMPLES (DEB_SAMPLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_s  (btn_s),
    .btn_db (btn_db)
  );

  logic              btn_db_q;
  logic              press;
  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              capture;
  logic              drop_set;
  logic [INST_W-1:0] wd_q;

  assign press = btn_db & ~btn_db_q;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (press) begin
          capture = 1'b1;
          state_d = FETCH_PEND;
        end
      end
      FETCH_PEND: begin
        // A press here is lost even if the pending word is accepted this cycle.
        if (press)
          drop_set = 1'b1;
        if (inst.inst_rdy)
          state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_IDLE;
      btn_db_q  <= 1'b0;
      wd_q      <= '0;
      drop_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_db_q <= btn_db;
      if (capture)
        wd_q <= sw_s;
      if (drop_set)
        drop_flag <= 1'b1;
    end
  end

  assign inst.inst_vld = (state_q == FETCH_PEND);
  assign inst.inst_wd  = wd_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with TICK_DIV=4, DEB_SAMPLES=3.
module tb_inst_fetch;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       btnS = 1'b0;
  logic       btn_db;
  logic       drop_flag;

  inst_fetch_if bus();

  inst_fetch #(.TICK_DIV(4), .DEB_SAMPLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btnS      (btnS),
    .inst      (bus),
    .btn_db    (btn_db),
    .drop_flag (drop_flag)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_wd = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard on acceptance, checks vld/wd hold under backpressure.
  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_vld", 32'(bus.inst_vld), 32'd1);
      check("hold_wd", 32'(bus.inst_wd), 32'(prev_wd));
    end
    if (!rst && bus.inst_vld && bus.inst_rdy) begin
      hs_cnt++;
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check("sb_wd", 32'(bus.inst_wd), 32'(exp_q.pop_front()));
    end
    prev_hold = !rst && bus.inst_vld && !bus.inst_rdy;
    prev_wd   = bus.inst_wd;
  end

  initial begin
    #300000;
    $display("FAIL timeout n_chk %0d", n_chk);
    $fatal(1, "bench did not finish");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fall();
    int n = 0;
    while (btn_db && n < 100) begin
      cyc(1);
      n++;
    end
    check("db_fall", 32'(btn_db), 32'd0);
    cyc(6);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!bus.inst_vld && n < 100) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(bus.inst_vld), 32'd1);
  endtask

  task automatic press(input logic [7:0] w);
    sw = w;
    cyc(3);
    btnS = 1'b1;
    exp_q.push_back(w);
    cyc(40);
    btnS = 1'b0;
    wait_fall();
  endtask

  initial begin
    int n;
    int h;
    logic [7:0] seq[4];
    seq[0] = 8'h04; seq[1] = 8'h13; seq[2] = 8'h86; seq[3] = 8'hE0;

    // Reset with the button held high.
    bus.inst_rdy = 1'b1;
    sw   = 8'h5A;
    btnS = 1'b1;
    rst  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_vld", 32'(bus.inst_vld), 32'd0);
      check("rst_wd", 32'(bus.inst_wd), 32'd0);
      check("rst_db", 32'(btn_db), 32'd0);
      check("rst_drop", 32'(drop_flag), 32'd0);
    end
    rst = 1'b0;
    exp_q.push_back(8'h5A);
    n = 0;
    while (!btn_db && n < 100) begin
      cyc(1);
      n++;
    end
    check("db_rise_lat", 32'(n), 32'd12);
    cyc(1);
    check("vld_after_db", 32'(bus.inst_vld), 32'd1);
    check("wd_after_db", 32'(bus.inst_wd), 32'h5A);
    btnS = 1'b0;
    wait_fall();
    check("rst_seq_drop", 32'(drop_flag), 32'd0);

    // Clean press, including release.
    h = hs_cnt;
    press(8'h34);
    cyc(8);
    check("clean_pulses", 32'(hs_cnt - h), 32'd1);

    // Bounce then stable high.
    h = hs_cnt;
    sw = 8'hC5;
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      btnS = 1'b1;
      cyc(3);
      btnS = 1'b0;
      cyc(3);
    end
    check("bounce_db", 32'(btn_db), 32'd0);
    check("bounce_none", 32'(hs_cnt - h), 32'd0);
    btnS = 1'b1;
    exp_q.push_back(8'hC5);
    cyc(40);
    btnS = 1'b0;
    wait_fall();
    check("bounce_one", 32'(hs_cnt - h), 32'd1);

    // Backpressure with a dropped second press.
    h = hs_cnt;
    bus.inst_rdy = 1'b0;
    sw = 8'h9B;
    cyc(3);
    btnS = 1'b1;
    exp_q.push_back(8'h9B);
    wait_vld("bp_vld_rise");
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("bp_vld", 32'(bus.inst_vld), 32'd1);
      check("bp_wd", 32'(bus.inst_wd), 32'h9B);
    end
    btnS = 1'b0;
    wait_fall();
    sw = 8'h01;
    cyc(3);
    btnS = 1'b1;
    cyc(40);
    check("bp_drop", 32'(drop_flag), 32'd1);
    check("bp_wd_kept", 32'(bus.inst_wd), 32'h9B);
    check("bp_vld_kept", 32'(bus.inst_vld), 32'd1);
    btnS = 1'b0;
    wait_fall();
    bus.inst_rdy = 1'b1;
    cyc(1);
    check("bp_vld_fall", 32'(bus.inst_vld), 32'd0);
    check("bp_pulses", 32'(hs_cnt - h), 32'd1);

    // Reset while an instruction is pending.
    bus.inst_rdy = 1'b0;
    sw = 8'h77;
    cyc(3);
    btnS = 1'b1;
    exp_q.push_back(8'h77);
    wait_vld("mid_vld_rise");
    btnS = 1'b0;
    rst  = 1'b1;
    cyc(1);
    check("mid_rst_vld", 32'(bus.inst_vld), 32'd0);
    check("mid_rst_wd", 32'(bus.inst_wd), 32'd0);
    check("mid_rst_drop", 32'(drop_flag), 32'd0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    cyc(24);
    check("mid_rst_idle", 32'(bus.inst_vld), 32'd0);
    bus.inst_rdy = 1'b1;

    // Calculator program: PUSH, PUSH, MULT, SEND.
    h = hs_cnt;
    for (int i = 0; i < 4; i++)
      press(seq[i]);
    cyc(8);
    check("seq_pulses", 32'(hs_cnt - h), 32'd4);
    check("seq_drop", 32'(drop_flag), 32'd0);
    check("seq_last_op", 32'(inst_opcode(bus.inst_wd)), 32'(OP_SEND));

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
